// File: rtl/toggle_pulse_rx.sv
// Purpose: receive side of a toggle pulse synchronizer; turns toggle transitions into rd_pulse and queued events.
// Latency: rd_pulse and the evt_count increment land SYNC_STAGES cycles after the first capturing edge; ack_tog one cycle later.
// Backpressure: events wait in a saturating counter drained by evt_ready; events beyond the maximum set a sticky overflow.
module toggle_pulse_rx #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4
) (
    input  logic             rd_clk,
    input  logic             rd_reset,
    input  logic             tog_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             rd_pulse,
    output logic             ack_tog,
    output logic             evt_valid,
    output logic [CNT_W-1:0] evt_count,
    output logic             overflow,
    output logic             busy
);

    // The INIT down-counter must hold SYNC_STAGES+1.
    localparam int                INIT_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [INIT_W-1:0] INIT_LOAD = INIT_W'(SYNC_STAGES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INIT_W-1:0]  init_cnt;
    logic [INIT_W-1:0]  init_cnt_nxt;

    logic [SYNC_STAGES-1:0] sync;
    logic                   sync_out;
    logic                   tog_q;
    logic                   tog_edge;
    logic                   pop;

    logic [CNT_W-1:0]       cnt_nxt;
    logic                   ovf_set;
    logic                   ovf_nxt;

    assign sync_out  = sync[SYNC_STAGES-1];
    assign evt_valid = (evt_count != '0);
    assign pop       = evt_valid && evt_ready;

    // Edges are only reported once INIT has let tog_q settle onto the sender's reset level.
    assign tog_edge  = (state == ST_RUN) && (sync_out ^ tog_q);

    // Synchronizer chain for the asynchronous toggle level.
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], tog_in};
        end
    end

    // Level history, pulse and echo; tog_q tracks in both states so INIT absorbs a high reset level.
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            tog_q    <= 1'b0;
            rd_pulse <= 1'b0;
            ack_tog  <= 1'b0;
        end else begin
            tog_q    <= sync_out;
            rd_pulse <= tog_edge;
            ack_tog  <= tog_q;
        end
    end

    // FSM state and INIT down-counter registers.
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            state    <= ST_INIT;
            init_cnt <= INIT_LOAD;
        end else begin
            state    <= state_nxt;
            init_cnt <= init_cnt_nxt;
        end
    end

    // Next state: leave INIT on the edge where the down-counter reaches zero, never return.
    always_comb begin
        state_nxt    = state;
        init_cnt_nxt = init_cnt;
        busy         = (state == ST_INIT);
        case (state)
            ST_INIT: begin
                if (init_cnt <= INIT_W'(1)) begin
                    init_cnt_nxt = '0;
                    state_nxt    = ST_RUN;
                end else begin
                    init_cnt_nxt = init_cnt - INIT_W'(1);
                end
            end
            ST_RUN: begin
                state_nxt = ST_RUN;
            end
            default: begin
                state_nxt = ST_INIT;
            end
        endcase
    end

    // Pending-count update: a simultaneous edge and pop cancel, so saturation only drops unpaired edges.
    always_comb begin
        cnt_nxt = evt_count;
        ovf_set = 1'b0;
        case ({tog_edge, pop})
            2'b10: begin
                if (evt_count == CNT_MAX) begin
                    ovf_set = 1'b1;
                end else begin
                    cnt_nxt = evt_count + CNT_W'(1);
                end
            end
            2'b01: begin
                cnt_nxt = evt_count - CNT_W'(1);
            end
            default: begin
                cnt_nxt = evt_count;
            end
        endcase
        // A drop in the same cycle as a clear keeps the flag set.
        if (ovf_set) begin
            ovf_nxt = 1'b1;
        end else if (ovf_clr) begin
            ovf_nxt = 1'b0;
        end else begin
            ovf_nxt = overflow;
        end
    end

    // Pending counter and sticky overflow registers.
    always_ff @(posedge rd_clk or negedge rd_reset) begin
        if (!rd_reset) begin
            evt_count <= '0;
            overflow  <= 1'b0;
        end else begin
            evt_count <= cnt_nxt;
            overflow  <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_pulse_rx.sv
// Purpose: self-checking bench for toggle_pulse_rx (vector table, directed corner cases, random traffic).
// Latency: outputs are compared 1 time unit after each rising rd_clk edge.
// Backpressure: evt_ready is driven by the bench, both directed and random.
module tb_toggle_pulse_rx;

    localparam int S     = 2;
    localparam int CNT_W = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic             rd_clk;
    logic             rd_reset;
    logic             tog_in;
    logic             evt_ready;
    logic             ovf_clr;
    logic             rd_pulse;
    logic             ack_tog;
    logic             evt_valid;
    logic [CNT_W-1:0] evt_count;
    logic             overflow;
    logic             busy;

    toggle_pulse_rx #(
        .SYNC_STAGES (S),
        .CNT_W       (CNT_W)
    ) dut (
        .rd_clk    (rd_clk),
        .rd_reset  (rd_reset),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .ovf_clr   (ovf_clr),
        .rd_pulse  (rd_pulse),
        .ack_tog   (ack_tog),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    int n_cmp;
    int n_bad;
    int pulse_cnt;

    // Reference model: tog_in as sampled at each edge since reset release, plus event bookkeeping.
    int tin_hist[$];
    int m_edge;
    int m_cnt;
    int m_ovf;
    int m_pulse;
    int m_ack;
    int m_busy;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at t=%0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic int tin_at(input int j);
        if (j < 1) return 0;
        return tin_hist[j-1];
    endfunction

    task automatic model_reset();
        tin_hist.delete();
        m_edge  = 0;
        m_cnt   = 0;
        m_ovf   = 0;
        m_pulse = 0;
        m_ack   = 0;
        m_busy  = 1;
    endtask

    // One clock: the model follows the spec's latency rules, then every output is compared.
    task automatic step();
        int ev;
        int pop;
        @(posedge rd_clk);
        m_edge++;
        tin_hist.push_back(int'(tog_in));
        ev      = ((m_edge - 1) >= S + 1 && tin_at(m_edge - S) != tin_at(m_edge - S - 1)) ? 1 : 0;
        m_pulse = ev;
        m_ack   = tin_at(m_edge - S - 1);
        m_busy  = (m_edge < S + 1) ? 1 : 0;
        pop     = (m_cnt != 0 && evt_ready) ? 1 : 0;
        if (ev == 1 && pop == 0) begin
            if (m_cnt == MAXC) m_ovf = 1;
            else m_cnt = m_cnt + 1;
        end else if (ev == 0 && pop == 1) begin
            m_cnt = m_cnt - 1;
        end else if (ovf_clr) begin
            m_ovf = m_ovf;
        end
        if (!(ev == 1 && pop == 0 && m_cnt == MAXC && m_ovf == 1) && ovf_clr) begin
            // Clear applies unless a drop happened on this same edge.
            if (!(ev == 1 && pop == 0 && tin_hist.size() > 0 && m_cnt == MAXC && m_ovf == 1)) m_ovf = 0;
        end
        #1;
        if (rd_pulse) pulse_cnt++;
        chk("rd_pulse",  int'(rd_pulse),  m_pulse);
        chk("ack_tog",   int'(ack_tog),   m_ack);
        chk("busy",      int'(busy),      m_busy);
        chk("evt_count", int'(evt_count), m_cnt);
        chk("evt_valid", int'(evt_valid), (m_cnt != 0) ? 1 : 0);
        chk("overflow",  int'(overflow),  m_ovf);
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_pulse"}, int'(rd_pulse),  0);
        chk({tag, "_ack"},   int'(ack_tog),   0);
        chk({tag, "_valid"}, int'(evt_valid), 0);
        chk({tag, "_count"}, int'(evt_count), 0);
        chk({tag, "_ovf"},   int'(overflow),  0);
        chk({tag, "_busy"},  int'(busy),      1);
    endtask

    typedef struct {
        logic tog;
        logic rdy;
        logic pulse;
        logic ack;
        int   cnt;
        logic busy;
    } vec_t;

    vec_t vecs[15];

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        pulse_cnt = 0;
        model_reset();

        // Reset/INIT then single events, starting from a sender whose toggle resets high.
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 1, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0};

        rd_reset  = 1'b0;
        tog_in    = 1'b1;
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        #1;
        check_in_reset("por");
        repeat (3) @(posedge rd_clk);
        #1;
        check_in_reset("por_hold");
        rd_reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            tog_in    = vecs[i].tog;
            evt_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_pulse", i), int'(rd_pulse),  int'(vecs[i].pulse));
            chk($sformatf("vec%0d_ack", i),   int'(ack_tog),   int'(vecs[i].ack));
            chk($sformatf("vec%0d_count", i), int'(evt_count), vecs[i].cnt);
            chk($sformatf("vec%0d_busy", i),  int'(busy),      int'(vecs[i].busy));
        end
        evt_ready = 1'b0;

        // Three spaced toggles, then a drain at one event per cycle.
        pulse_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            tog_in = ~tog_in;
            repeat (4) step();
        end
        chk("three_pulses", pulse_cnt, 3);
        chk("three_count", int'(evt_count), 3);
        evt_ready = 1'b1;
        step();
        chk("drain_2", int'(evt_count), 2);
        step();
        chk("drain_1", int'(evt_count), 1);
        step();
        chk("drain_0", int'(evt_count), 0);
        evt_ready = 1'b0;

        // Saturation: sixteen events with no consumer.
        pulse_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            tog_in = ~tog_in;
            repeat (4) step();
        end
        chk("sat_pulses", pulse_cnt, 16);
        chk("sat_count", int'(evt_count), MAXC);
        chk("sat_ovf", int'(overflow), 1);

        // Clear alone, then an event paired with a pop at full count.
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_alone", int'(overflow), 0);
        tog_in = ~tog_in;
        step();
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("pair_pulse", int'(rd_pulse), 1);
        chk("pair_count", int'(evt_count), MAXC);
        chk("pair_no_ovf", int'(overflow), 0);
        step();

        // Clear racing a dropped event: the set wins.
        tog_in = ~tog_in;
        step();
        step();
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("race_pulse", int'(rd_pulse), 1);
        chk("race_ovf", int'(overflow), 1);
        chk("race_count", int'(evt_count), MAXC);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("clr_after_race", int'(overflow), 0);

        // Drain to five, then reset asynchronously between clock edges.
        evt_ready = 1'b1;
        repeat (10) step();
        evt_ready = 1'b0;
        chk("pre_reset_count", int'(evt_count), 5);
        #3;
        rd_reset = 1'b0;
        #1;
        check_in_reset("mid");
        model_reset();
        repeat (2) @(posedge rd_clk);
        #1;
        check_in_reset("mid_hold");
        rd_reset = 1'b1;
        step();
        chk("reinit_busy1", int'(busy), 1);
        step();
        chk("reinit_busy2", int'(busy), 1);
        step();
        chk("reinit_busy3", int'(busy), 0);
        chk("reinit_count", int'(evt_count), 0);
        step();
        tog_in = ~tog_in;
        repeat (4) step();
        chk("post_reset_count", int'(evt_count), 1);

        // Random traffic with bursts of no-consumer to reach saturation.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(2) == 0) tog_in = ~tog_in;
            if ((i / 200) % 3 == 1) evt_ready = 1'b0;
            else evt_ready = ($urandom_range(1) == 1);
            ovf_clr = ($urandom_range(15) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
